// File: rtl/ps2_rx_frame_pkg.sv
// ============================================================================
// Module : ps2_rx_frame_pkg
// Brief  : Shared frame constants, FSM state type and parity helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ps2_rx_frame_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;
    // Start bit is never stored: data + parity + stop only
    localparam int PS2_SHIFT_BITS = PS2_FRAME_BITS - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DPS  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS:0] bits);
        return ^bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx_frame_if.sv
// ============================================================================
// Module : ps2_rx_frame_if
// Brief  : PS/2 line inputs and received-byte outputs of the frame receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ps2_rx_frame_if;
    import ps2_rx_frame_pkg::*;

    logic                     ps2d;
    logic                     ps2c;
    logic                     rx_en;
    logic [PS2_DATA_BITS-1:0] dout;
    logic                     rx_done_tick;
    logic                     parity_err;
    logic                     frame_err;
    logic                     busy;

    modport master (
        output ps2d, ps2c, rx_en,
        input  dout, rx_done_tick, parity_err, frame_err, busy
    );

    modport slave (
        input  ps2d, ps2c, rx_en,
        output dout, rx_done_tick, parity_err, frame_err, busy
    );

endinterface

`default_nettype wire

// File: rtl/ps2_rx_frame_clk_filter.sv
// ============================================================================
// Module : ps2_rx_frame_clk_filter
// Brief  : ps2c synchroniser, run-length glitch filter and falling-edge tick.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ps2_rx_frame_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic ps2c_raw,
    output logic      fall_tick
);

    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] hist;
    logic                  filt;
    logic                  filt_next;

    // All-ones reset matches an idle bus, so releasing reset cannot fake an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '1;
            hist <= '1;
            filt <= 1'b1;
        end else begin
            sync <= {sync[0], ps2c_raw};
            hist <= {hist[FILTER_LEN-2:0], sync[1]};
            filt <= filt_next;
        end
    end

    always_comb begin
        filt_next = filt;
        if (&hist)
            filt_next = 1'b1;
        else if (~|hist)
            filt_next = 1'b0;
    end

    assign fall_tick = filt & ~filt_next;

endmodule

`default_nettype wire

// File: rtl/ps2_rx_frame.sv
// ============================================================================
// Module : ps2_rx_frame
// Brief  : PS/2 device-to-host 11-bit frame receiver with parity/stop/timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ps2_rx_frame #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int TO_W        = 17
) (
    input  wire logic      clk,
    input  wire logic      reset,
    ps2_rx_frame_if.slave  bus
);
    import ps2_rx_frame_pkg::*;

    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      N_START   = 4'(PS2_SHIFT_BITS - 1);

    state_t                    state, state_next;
    logic [3:0]                n, n_next;
    logic [PS2_SHIFT_BITS-1:0] b, b_next;
    logic [TO_W-1:0]           cnt, cnt_next;
    logic [PS2_DATA_BITS-1:0]  dout_next;
    logic                      done_next, perr_next, ferr_next, busy_next;
    logic [1:0]                d_sync;
    logic                      ps2d_s;
    logic                      fall_tick;

    ps2_rx_frame_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c_raw  (bus.ps2c),
        .fall_tick (fall_tick)
    );

    assign ps2d_s = d_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_sync           <= '1;
            state            <= ST_IDLE;
            n                <= '0;
            b                <= '0;
            cnt              <= '0;
            bus.dout         <= '0;
            bus.rx_done_tick <= 1'b0;
            bus.parity_err   <= 1'b0;
            bus.frame_err    <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            d_sync           <= {d_sync[0], bus.ps2d};
            state            <= state_next;
            n                <= n_next;
            b                <= b_next;
            cnt              <= cnt_next;
            bus.dout         <= dout_next;
            bus.rx_done_tick <= done_next;
            bus.parity_err   <= perr_next;
            bus.frame_err    <= ferr_next;
            bus.busy         <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        n_next     = n;
        b_next     = b;
        cnt_next   = cnt;
        dout_next  = bus.dout;
        done_next  = 1'b0;
        perr_next  = 1'b0;
        ferr_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                // rx_en is only consulted here, so dropping it mid-frame is harmless
                if (fall_tick && bus.rx_en && !ps2d_s) begin
                    state_next = ST_DPS;
                    n_next     = N_START;
                    cnt_next   = '0;
                end
            end
            ST_DPS: begin
                if (fall_tick) begin
                    b_next   = {ps2d_s, b[PS2_SHIFT_BITS-1:1]};
                    cnt_next = '0;
                    if (n == 4'd0)
                        state_next = ST_LOAD;
                    else
                        n_next = n - 4'd1;
                end else if (cnt == TO_LAST) begin
                    ferr_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + TO_W'(1);
                end
            end
            ST_LOAD: begin
                state_next = ST_IDLE;
                if (!b[PS2_SHIFT_BITS-1])
                    ferr_next = 1'b1;
                else if (!odd_parity_ok(b[PS2_DATA_BITS:0]))
                    perr_next = 1'b1;
                else begin
                    dout_next = b[PS2_DATA_BITS-1:0];
                    done_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        busy_next = (state_next != ST_IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_frame.sv
// ============================================================================
// Module : tb_ps2_rx_frame
// Brief  : Self-checking bench for ps2_rx_frame against a frame-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_rx_frame;

    localparam int TIMEOUT = 1000;
    localparam int O_NONE = 0, O_DONE = 1, O_PERR = 2, O_FERR = 3;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0, errors = 0;

    int   n_done = 0, n_perr = 0, n_ferr = 0, n_multi = 0;
    int   n_dout_glitch = 0, n_busy_rise = 0;
    int   ferr_cyc = 0, last_fall_cyc = 0;
    logic [7:0] done_dout = 8'h00, prev_dout = 8'h00, exp_dout = 8'h00;
    logic prev_busy = 1'b0;

    ps2_rx_frame_if bus ();

    ps2_rx_frame #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT), .TO_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_done_tick) begin n_done++; done_dout = bus.dout; end
            if (bus.parity_err) n_perr++;
            if (bus.frame_err) begin n_ferr++; ferr_cyc = cyc; end
            if ((32'(bus.rx_done_tick) + 32'(bus.parity_err) + 32'(bus.frame_err)) > 1) n_multi++;
            if (bus.dout !== prev_dout && !bus.rx_done_tick) n_dout_glitch++;
            if (bus.busy && !prev_busy) n_busy_rise++;
        end
        prev_dout = bus.dout;
        prev_busy = bus.busy;
    end

    // Frame layout on the wire: bit0 start, bits 1..8 data LSB first, 9 parity, 10 stop
    function automatic logic [10:0] make_frame(input logic [7:0] data, input logic par_ok,
                                               input logic stop);
        logic par;
        par = (($countones(data) % 2) == 0) ? 1'b1 : 1'b0;
        if (!par_ok) par = ~par;
        return {stop, par, data, 1'b0};
    endfunction

    function automatic int model(input logic en, input logic [10:0] f);
        if (!en || f[0]) return O_NONE;
        if (!f[10]) return O_FERR;
        if (($countones(f[9:1]) % 2) == 0) return O_PERR;
        return O_DONE;
    endfunction

    task automatic send_frame(input logic [10:0] f, input int nbits, input int en_off_bit);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2d = f[i];
            if (i == en_off_bit) bus.rx_en = 1'b0;
            repeat (20) @(negedge clk);
            bus.ps2c = 1'b0;
            last_fall_cyc = cyc;
            repeat (20) @(negedge clk);
            bus.ps2c = 1'b1;
        end
        @(negedge clk);
        bus.ps2d = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", bus.dout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++;
        if ({bus.rx_done_tick, bus.parity_err, bus.frame_err} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got %b want 000", {bus.rx_done_tick, bus.parity_err, bus.frame_err});
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_good_byte;
        int sd = n_done, sp = n_perr, sf = n_ferr, sb = n_busy_rise;
        send_frame(make_frame(8'h1C, 1'b1, 1'b1), 11, -1);
        exp_dout = 8'h1C;
        checks++; if (n_done !== sd + 1) begin errors++; $display("FAIL good_done got %0d want %0d", n_done - sd, 1); end
        checks++; if (n_perr + n_ferr !== sp + sf) begin errors++; $display("FAIL good_errs got %0d want 0", n_perr + n_ferr - sp - sf); end
        checks++; if (bus.dout !== exp_dout) begin errors++; $display("FAIL good_dout got %h want %h", bus.dout, exp_dout); end
        checks++; if (n_busy_rise !== sb + 1) begin errors++; $display("FAIL good_busy_rise got %0d want 1", n_busy_rise - sb); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL good_busy_end got %b want 0", bus.busy); end
    endtask

    task automatic test_parity_err;
        int sd = n_done, sp = n_perr;
        send_frame(make_frame(8'hF0, 1'b0, 1'b1), 11, -1);
        checks++; if (n_perr !== sp + 1) begin errors++; $display("FAIL perr_pulse got %0d want 1", n_perr - sp); end
        checks++; if (n_done !== sd) begin errors++; $display("FAIL perr_nodone got %0d want 0", n_done - sd); end
        checks++; if (bus.dout !== exp_dout) begin errors++; $display("FAIL perr_dout got %h want %h", bus.dout, exp_dout); end
    endtask

    task automatic test_stop_err;
        int sd = n_done, sp = n_perr, sf = n_ferr;
        send_frame(make_frame(8'h5A, 1'b1, 1'b0), 11, -1);
        checks++; if (n_ferr !== sf + 1) begin errors++; $display("FAIL stop_ferr got %0d want 1", n_ferr - sf); end
        checks++; if (n_done + n_perr !== sd + sp) begin errors++; $display("FAIL stop_other got %0d want 0", n_done + n_perr - sd - sp); end
        checks++; if (bus.dout !== exp_dout) begin errors++; $display("FAIL stop_dout got %h want %h", bus.dout, exp_dout); end
    endtask

    task automatic test_timeout;
        int sd = n_done, sf = n_ferr, delta;
        send_frame(make_frame(8'h77, 1'b1, 1'b1), 5, -1);
        repeat (1200) @(negedge clk);
        delta = ferr_cyc - last_fall_cyc;
        checks++; if (n_ferr !== sf + 1) begin errors++; $display("FAIL to_ferr got %0d want 1", n_ferr - sf); end
        checks++;
        if (delta < TIMEOUT || delta > TIMEOUT + 25) begin
            errors++; $display("FAIL to_latency got %0d want %0d..%0d", delta, TIMEOUT, TIMEOUT + 25);
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL to_busy got %b want 0", bus.busy); end
        send_frame(make_frame(8'h12, 1'b1, 1'b1), 11, -1);
        exp_dout = 8'h12;
        checks++; if (n_done !== sd + 1) begin errors++; $display("FAIL to_recover_done got %0d want 1", n_done - sd); end
        checks++; if (bus.dout !== exp_dout) begin errors++; $display("FAIL to_recover_dout got %h want %h", bus.dout, exp_dout); end
    endtask

    task automatic test_glitch_rx_en;
        int sb = n_busy_rise, sd = n_done, sp = n_perr, sf = n_ferr;
        @(negedge clk); bus.ps2c = 1'b0;
        repeat (3) @(negedge clk); bus.ps2c = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (n_busy_rise !== sb || bus.busy !== 1'b0) begin
            errors++; $display("FAIL glitch_busy got %0d rises want 0", n_busy_rise - sb);
        end
        bus.rx_en = 1'b0;
        send_frame(make_frame(8'h1C, 1'b1, 1'b1), 11, -1);
        bus.rx_en = 1'b1;
        checks++; if (n_done + n_perr + n_ferr !== sd + sp + sf) begin
            errors++; $display("FAIL rxen_off_pulses got %0d want 0", n_done + n_perr + n_ferr - sd - sp - sf);
        end
        checks++; if (n_busy_rise !== sb) begin errors++; $display("FAIL rxen_off_busy got %0d want 0", n_busy_rise - sb); end
    endtask

    task automatic test_rx_en_drop;
        int sd = n_done;
        send_frame(make_frame(8'h3A, 1'b1, 1'b1), 11, 2);
        bus.rx_en = 1'b1;
        exp_dout = 8'h3A;
        checks++; if (n_done !== sd + 1) begin errors++; $display("FAIL endrop_done got %0d want 1", n_done - sd); end
        checks++; if (bus.dout !== exp_dout) begin errors++; $display("FAIL endrop_dout got %h want %h", bus.dout, exp_dout); end
    endtask

    task automatic test_reset_midframe;
        int sd;
        send_frame(make_frame(8'h55, 1'b1, 1'b1), 4, -1);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b want 1", bus.busy); end
        #2 reset = 1'b1;
        #1;
        exp_dout = 8'h00;
        checks++; if (bus.dout !== exp_dout) begin errors++; $display("FAIL midrst_dout got %h want 00", bus.dout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        sd = n_done;
        send_frame(make_frame(8'hE0, 1'b1, 1'b1), 11, -1);
        exp_dout = 8'hE0;
        checks++; if (n_done !== sd + 1) begin errors++; $display("FAIL midrst_done got %0d want 1", n_done - sd); end
        checks++; if (bus.dout !== exp_dout) begin errors++; $display("FAIL midrst_after_dout got %h want %h", bus.dout, exp_dout); end
    endtask

    task automatic test_random;
        int ed = n_done, ep = n_perr, ef = n_ferr, kind, res;
        logic [7:0]  data;
        logic [10:0] f;
        logic        en;
        for (int k = 0; k < 24; k++) begin
            data = 8'($urandom);
            kind = $urandom_range(0, 9);
            f    = make_frame(data, kind != 0, kind != 1);
            en   = (kind != 2);
            bus.rx_en = en;
            send_frame(f, 11, -1);
            bus.rx_en = 1'b1;
            res = model(en, f);
            if (res == O_DONE) begin ed++; exp_dout = data; end
            if (res == O_PERR) ep++;
            if (res == O_FERR) ef++;
            checks++;
            if (n_done !== ed || n_perr !== ep || n_ferr !== ef) begin
                errors++;
                $display("FAIL rand[%0d] counts got %0d/%0d/%0d want %0d/%0d/%0d", k, n_done, n_perr, n_ferr, ed, ep, ef);
            end
            checks++; if (bus.dout !== exp_dout) begin errors++; $display("FAIL rand[%0d] dout got %h want %h", k, bus.dout, exp_dout); end
        end
    endtask

    task automatic test_exclusive;
        checks++; if (n_multi !== 0) begin errors++; $display("FAIL pulse_overlap got %0d want 0", n_multi); end
        checks++; if (n_dout_glitch !== 0) begin errors++; $display("FAIL dout_changed_without_done got %0d want 0", n_dout_glitch); end
        checks++; if (done_dout !== exp_dout) begin errors++; $display("FAIL last_done_dout got %h want %h", done_dout, exp_dout); end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        bus.ps2c  = 1'b1;
        bus.ps2d  = 1'b1;
        bus.rx_en = 1'b1;
        test_reset;
        test_good_byte;
        test_parity_err;
        test_stop_err;
        test_timeout;
        test_glitch_rx_en;
        test_rx_en_drop;
        test_reset_midframe;
        test_random;
        test_exclusive;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
